// File: rtl/alu_cond_exec_pkg.sv
// Shared types for the conditional-execute ALU stage: op codes, ARM condition codes, flag bit positions.
package alu_cond_exec_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_op_e;

  typedef enum logic [3:0] {
    CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
    CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
    CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
    CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_cond_exec_condcheck.sv
// ARM condition-field evaluator against the current {N,Z,C,V}.
// Purely combinational (0 cycles), no flow control.
module condcheck
  import alu_cond_exec_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = Flags[FLAG_N];
  assign w_z = Flags[FLAG_Z];
  assign w_c = Flags[FLAG_C];
  assign w_v = Flags[FLAG_V];

  always_comb begin
    CondEx = 1'b0;
    case (cond_e'(Cond))
      CC_EQ: CondEx = w_z;
      CC_NE: CondEx = ~w_z;
      CC_CS: CondEx = w_c;
      CC_CC: CondEx = ~w_c;
      CC_MI: CondEx = w_n;
      CC_PL: CondEx = ~w_n;
      CC_VS: CondEx = w_v;
      CC_VC: CondEx = ~w_v;
      CC_HI: CondEx = w_c & ~w_z;
      CC_LS: CondEx = ~w_c | w_z;
      CC_GE: CondEx = (w_n == w_v);
      CC_LT: CondEx = (w_n != w_v);
      CC_GT: CondEx = ~w_z & (w_n == w_v);
      CC_LE: CondEx = w_z | (w_n != w_v);
      CC_AL: CondEx = 1'b1;
      CC_NV: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_cond_exec.sv
// Conditional-execute ALU stage: ADD/SUB/AND/ORR, gated flag writes and write-enables, skip counter.
// Latency 1 cycle, one instruction per cycle; never stalls, flush kills the presented instruction.
module alu_cond_exec
  import alu_cond_exec_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  input  logic        flush,
  input  logic [1:0]  ALUControl,
  input  logic [1:0]  FlagW,
  input  logic [3:0]  Cond,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        PCS,
  input  logic        RegW,
  input  logic        MemW,
  input  logic        NoWrite,
  output logic        valid_out,
  output logic [31:0] ALUResult,
  output logic [3:0]  Flags,
  output logic        PCSrc,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        CondEx,
  output logic [15:0] SkipCount
);

  logic        r_valid;
  logic [31:0] r_result;
  logic [3:0]  r_flags;
  logic        r_pcsrc;
  logic        r_regwrite;
  logic        r_memwrite;
  logic        r_condex;
  logic [15:0] r_skip;

  logic        w_accept;
  logic        w_cond_ex;
  logic        w_is_sub;
  logic        w_is_arith;
  logic [31:0] w_b;
  logic [32:0] w_sum;
  logic [31:0] w_result;
  logic        w_c;
  logic        w_v;
  logic [3:0]  w_flags_next;

  assign w_accept = valid_in & ~flush;

  // Condition is judged on the registered flags, i.e. before this instruction's own update.
  condcheck u_condcheck (
    .Cond   (Cond),
    .Flags  (r_flags),
    .CondEx (w_cond_ex)
  );

  // SUB is A + ~B + 1 so a single adder provides carry-out and overflow for both ops.
  assign w_is_sub   = (alu_op_e'(ALUControl) == ALU_SUB);
  assign w_is_arith = ~ALUControl[1];
  assign w_b        = w_is_sub ? ~SrcB : SrcB;
  assign w_sum      = {1'b0, SrcA} + {1'b0, w_b} + {32'd0, w_is_sub};

  always_comb begin
    w_result = w_sum[31:0];
    case (alu_op_e'(ALUControl))
      ALU_AND: w_result = SrcA & SrcB;
      ALU_ORR: w_result = SrcA | SrcB;
      default: w_result = w_sum[31:0];
    endcase
  end

  assign w_c = w_is_arith & w_sum[32];
  assign w_v = w_is_arith & (SrcA[31] == w_b[31]) & (w_sum[31] != SrcA[31]);

  always_comb begin
    w_flags_next = r_flags;
    if (FlagW[1]) begin
      w_flags_next[FLAG_N] = w_result[31];
      w_flags_next[FLAG_Z] = ~|w_result;
    end
    if (FlagW[0]) begin
      w_flags_next[FLAG_C] = w_c;
      w_flags_next[FLAG_V] = w_v;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid    <= 1'b0;
      r_result   <= 32'd0;
      r_flags    <= 4'b0000;
      r_pcsrc    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memwrite <= 1'b0;
      r_condex   <= 1'b0;
      r_skip     <= 16'd0;
    end else begin
      r_valid    <= w_accept;
      r_pcsrc    <= w_accept & w_cond_ex & PCS;
      r_regwrite <= w_accept & w_cond_ex & RegW & ~NoWrite;
      r_memwrite <= w_accept & w_cond_ex & MemW;
      r_condex   <= w_accept & w_cond_ex;
      if (w_accept) begin
        r_result <= w_result;
      end
      if (w_accept && w_cond_ex) begin
        r_flags <= w_flags_next;
      end
      if (w_accept && !w_cond_ex && (r_skip != 16'hFFFF)) begin
        r_skip <= r_skip + 16'd1;
      end
    end
  end

  assign valid_out = r_valid;
  assign ALUResult = r_result;
  assign Flags     = r_flags;
  assign PCSrc     = r_pcsrc;
  assign RegWrite  = r_regwrite;
  assign MemWrite  = r_memwrite;
  assign CondEx    = r_condex;
  assign SkipCount = r_skip;

endmodule

// File: tb/tb_alu_cond_exec.sv
// Randomized + directed bench for alu_cond_exec against an arithmetic reference model.
module tb_alu_cond_exec;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_in, flush;
  logic [1:0]  ALUControl, FlagW;
  logic [3:0]  Cond;
  logic [31:0] SrcA, SrcB;
  logic        PCS, RegW, MemW, NoWrite;
  logic        valid_out;
  logic [31:0] ALUResult;
  logic [3:0]  Flags;
  logic        PCSrc, RegWrite, MemWrite, CondEx;
  logic [15:0] SkipCount;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [3:0]  m_flags;
  logic [31:0] m_res;
  logic [15:0] m_skip;
  logic        m_valid, m_pcsrc, m_regw, m_memw, m_ce;

  alu_cond_exec dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .flush(flush),
    .ALUControl(ALUControl), .FlagW(FlagW), .Cond(Cond), .SrcA(SrcA), .SrcB(SrcB),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .valid_out(valid_out), .ALUResult(ALUResult), .Flags(Flags),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
    .SkipCount(SkipCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string pfx);
    chk({pfx, ".valid_out"}, {31'd0, valid_out}, {31'd0, m_valid});
    chk({pfx, ".ALUResult"}, ALUResult, m_res);
    chk({pfx, ".Flags"},     {28'd0, Flags}, {28'd0, m_flags});
    chk({pfx, ".PCSrc"},     {31'd0, PCSrc}, {31'd0, m_pcsrc});
    chk({pfx, ".RegWrite"},  {31'd0, RegWrite}, {31'd0, m_regw});
    chk({pfx, ".MemWrite"},  {31'd0, MemWrite}, {31'd0, m_memw});
    chk({pfx, ".CondEx"},    {31'd0, CondEx}, {31'd0, m_ce});
    chk({pfx, ".SkipCount"}, {16'd0, SkipCount}, {16'd0, m_skip});
  endtask

  function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_flags = 4'b0000; m_res = 32'd0; m_skip = 16'd0;
    m_valid = 1'b0; m_pcsrc = 1'b0; m_regw = 1'b0; m_memw = 1'b0; m_ce = 1'b0;
  endtask

  task automatic apply(input logic v, input logic f, input logic [1:0] op, input logic [1:0] fw,
                       input logic [3:0] cc, input logic [31:0] a, input logic [31:0] b,
                       input logic pcs, input logic regw, input logic memw, input logic nowr,
                       input bit do_chk);
    logic acc, ce, fc, fv;
    logic [31:0] res;
    longint s;
    @(negedge clk);
    valid_in = v; flush = f; ALUControl = op; FlagW = fw; Cond = cc;
    SrcA = a; SrcB = b; PCS = pcs; RegW = regw; MemW = memw; NoWrite = nowr;
    acc = v && !f;
    ce  = cond_ok(cc, m_flags);
    fc = 1'b0; fv = 1'b0; s = 0;
    case (op)
      2'd0: begin
        res = a + b;
        fc  = (longint'(a) + longint'(b)) >= 64'sh1_0000_0000;
        s   = longint'($signed(a)) + longint'($signed(b));
        fv  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      2'd1: begin
        res = a - b;
        fc  = (a >= b);
        s   = longint'($signed(a)) - longint'($signed(b));
        fv  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      2'd2: res = a & b;
      default: res = a | b;
    endcase
    if (acc) begin
      m_valid = 1'b1; m_res = res; m_ce = ce;
      m_pcsrc = pcs && ce; m_regw = regw && ce && !nowr; m_memw = memw && ce;
      if (ce) begin
        if (fw[1]) begin m_flags[3] = res[31]; m_flags[2] = (res == 32'd0); end
        if (fw[0]) begin m_flags[1] = fc; m_flags[0] = fv; end
      end else if (m_skip != 16'hFFFF) begin
        m_skip = m_skip + 16'd1;
      end
    end else begin
      m_valid = 1'b0; m_ce = 1'b0; m_pcsrc = 1'b0; m_regw = 1'b0; m_memw = 1'b0;
    end
    @(posedge clk);
    #1;
    if (do_chk) check_all("vec");
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [15:0] skip_before;
    reset_n = 1'b0; valid_in = 1'b0; flush = 1'b0; ALUControl = 2'd0; FlagW = 2'd0;
    Cond = 4'h0; SrcA = 32'd0; SrcB = 32'd0; PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) reset_n = 1'b1;

    // First instructions after reset see flags 0000: EQ fails, NE passes
    apply(1, 0, 2'd0, 2'b00, 4'h0, 32'd1, 32'd1, 0, 1, 0, 0, 1);
    chk("post_rst_eq_condex", {31'd0, CondEx}, 32'd0);
    apply(1, 0, 2'd0, 2'b00, 4'h1, 32'd1, 32'd1, 0, 1, 0, 0, 1);
    chk("post_rst_ne_condex", {31'd0, CondEx}, 32'd1);

    // SUB 5-5 always
    apply(1, 0, 2'd1, 2'b11, 4'hE, 32'd5, 32'd5, 0, 0, 0, 0, 1);
    chk("sub55_result", ALUResult, 32'd0);
    chk("sub55_flags", {28'd0, Flags}, 32'h6);

    // ADD 1+2 under EQ, then NE skipped back-to-back
    apply(1, 0, 2'd0, 2'b00, 4'h0, 32'd1, 32'd2, 0, 1, 0, 0, 1);
    chk("eq_add_result", ALUResult, 32'd3);
    chk("eq_add_regwrite", {31'd0, RegWrite}, 32'd1);
    skip_before = m_skip;
    apply(1, 0, 2'd0, 2'b00, 4'h1, 32'd1, 32'd2, 0, 1, 0, 0, 1);
    chk("ne_skip_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("ne_skip_count", {16'd0, SkipCount}, {16'd0, skip_before + 16'd1});

    // Signed overflow on ADD
    apply(1, 0, 2'd0, 2'b11, 4'hE, 32'h7FFF_FFFF, 32'd1, 1, 1, 1, 0, 1);
    chk("ovf_result", ALUResult, 32'h8000_0000);
    chk("ovf_flags", {28'd0, Flags}, 32'h9);

    // AND with FlagW=10 keeps C from the prior SUB 6-5 (flags 0010)
    apply(1, 0, 2'd1, 2'b11, 4'hE, 32'd6, 32'd5, 0, 0, 0, 0, 1);
    apply(1, 0, 2'd2, 2'b10, 4'hE, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 0, 0, 0, 0, 1);
    chk("and_keep_c_flags", {28'd0, Flags}, 32'h6);

    // Flushed instruction then reset mid-stream
    apply(1, 1, 2'd1, 2'b11, 4'hE, 32'd3, 32'd3, 1, 1, 1, 0, 1);
    @(negedge clk);
    valid_in = 1'b1; flush = 1'b0; ALUControl = 2'd0; FlagW = 2'b11; Cond = 4'hE;
    SrcA = 32'hFFFF_FFFF; SrcB = 32'd1;
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all("rst_async");
    @(posedge clk);
    #1 check_all("rst_held");
    @(negedge clk);
    reset_n = 1'b1; valid_in = 1'b0;
    apply(1, 0, 2'd0, 2'b00, 4'h0, 32'd9, 32'd9, 0, 1, 0, 0, 1);
    chk("rst2_eq_condex", {31'd0, CondEx}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      apply($urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0,
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            pick_operand(), pick_operand(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
    end

    // Skip counter saturation
    for (int i = 0; i < 65537; i++) begin
      apply(1, 0, 2'd0, 2'b11, 4'hF, 32'd1, 32'd1, 1, 1, 1, 0, 0);
    end
    check_all("sat");
    chk("sat_count", {16'd0, SkipCount}, 32'h0000_FFFF);
    apply(1, 0, 2'd0, 2'b11, 4'hF, 32'd1, 32'd1, 1, 1, 1, 0, 1);
    chk("sat_hold", {16'd0, SkipCount}, 32'h0000_FFFF);
    apply(1, 0, 2'd0, 2'b11, 4'hE, 32'd1, 32'd1, 1, 1, 1, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_cond_exec.md
ALU_COND_EXEC -- requirements
Module: alu_cond_exec

Interface
REQ-001 The block SHALL have these ports, one clock and an asynchronous active-low reset (clock and reset first):
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 valid_in  input  1  an instruction is presented this cycle.
REQ-005 flush  input  1  kill the instruction presented this cycle.
REQ-006 ALUControl  input  2  operation code: 00 ADD, 01 SUB, 10 AND, 11 ORR (the ALU-decoder encoding).
REQ-007 FlagW  input  2  flag-write enables: bit1 = N,Z; bit0 = C,V.
REQ-008 Cond  input  4  ARM condition field.
REQ-009 SrcA, SrcB  input  32 each  operands.
REQ-010 PCS, RegW, MemW, NoWrite  input  1 each  unconditional write intents from the main decoder.
REQ-011 valid_out  output  1  registered results are valid.
REQ-012 ALUResult  output  32  registered result.
REQ-013 Flags  output  4  current {N,Z,C,V} register.
REQ-014 PCSrc, RegWrite, MemWrite, CondEx  output  1 each  registered, condition-gated controls.
REQ-015 SkipCount  output  16  count of condition-failed instructions.

Function
REQ-016 An instruction is accepted when valid_in=1 and flush=0; if flush=1 in the same cycle, flush wins and the instruction is discarded.
REQ-017 Latency SHALL be exactly 1 cycle from acceptance to valid_out=1; one instruction per cycle, with no stall.
REQ-018 If no instruction is accepted in a cycle, the next cycle SHALL have valid_out=0, PCSrc=RegWrite=MemWrite=CondEx=0, and ALUResult holds its previous value.
REQ-019 ADD SHALL compute SrcA+SrcB; SUB SHALL compute SrcA+~SrcB+1; AND and ORR are bitwise; all results are 32-bit with wrap-around.
REQ-020 Computed flags: N=result[31]; Z=(result==0).
REQ-021 Computed C SHALL be the carry-out of bit 31 for ADD/SUB and 0 for AND/ORR.
REQ-022 Computed V SHALL be (A[31]==B'[31])&&(res[31]!=A[31]) for ADD/SUB, where B' is the SUB-inverted operand, and 0 for AND/ORR.
REQ-023 CondEx SHALL be evaluated against the Flags register value before this instruction's update.
REQ-024 Condition encoding: 0 EQ Z, 1 NE !Z, 2 CS C, 3 CC !C, 4 MI N, 5 PL !N, 6 VS V, 7 VC !V.
REQ-025 Condition encoding (cont.): 8 HI C&!Z, 9 LS !C|Z, A GE N==V, B LT N!=V, C GT !Z&(N==V), D LE Z|(N!=V), E AL 1, F never 0.
REQ-026 On the edge ending an accepted instruction with CondEx=1, N,Z SHALL update iff FlagW[1], and C,V SHALL update iff FlagW[0].
REQ-027 If CondEx=0, or the instruction is not accepted, Flags SHALL NOT change.
REQ-028 Registered controls: PCSrc=PCS&CondEx, RegWrite=RegW&CondEx&!NoWrite, MemWrite=MemW&CondEx.
REQ-029 A back-to-back instruction SHALL observe flags written by its predecessor, with no hazard bubble.
REQ-030 SkipCount SHALL increment by 1 per accepted instruction with CondEx=0 and saturate at 16'hFFFF.

Reset
REQ-031 On reset_n=0, asynchronously: valid_out=0, ALUResult=0, Flags=4'b0000, PCSrc=RegWrite=MemWrite=CondEx=0, SkipCount=0.
REQ-032 An instruction presented in a cycle during which reset is asserted SHALL be lost, and no flags SHALL be written.
REQ-033 The first accepted instruction after reset release SHALL see Flags=0000, so EQ fails and NE passes.

Structure
REQ-034 A shared package SHALL hold: the ALU op enum (ADD/SUB/AND/ORR), the condition-code enum (EQ..NV), and flag index constants N=3, Z=2, C=1, V=0.
REQ-035 Condition evaluation SHALL be a separate combinational sub-module, condcheck (Cond, Flags -> CondEx).
REQ-036 The ALU, flag register, output registers and counter SHALL reside in alu_cond_exec.

Verification
REQ-037 SUB, SrcA=5, SrcB=5, FlagW=11, Cond=E: next cycle ALUResult=0, CondEx=1; Flags=0110 (Z=1, C=1).
REQ-038 Follow REQ-037 with Cond=0 (EQ), ADD 1+2, RegW=1: ALUResult=3, RegWrite=1; then Cond=1 (NE): CondEx=0, RegWrite=0, SkipCount=1.
REQ-039 ADD 0x7FFFFFFF+1, FlagW=11: ALUResult=0x80000000, Flags=1001 (N=1, V=1).
REQ-040 AND 0xF0F0F0F0&0x0F0F0F0F, FlagW=10, with prior C=1: Flags N,Z=01 and C preserved at 1.
REQ-041 valid_in=1 with flush=1, then reset_n pulsed low mid-stream: no flag change, valid_out=0, all outputs 0 per REQ-031.
REQ-042 65537 consecutive Cond=F instructions: SkipCount holds at 0xFFFF.
